// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, master ids and
// default widths.
package dmem_arb_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_WORD_AW = 14;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, and under contention the
// master that did not win last time goes next.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;
  assign gnt_id    = (req == 2'b11) ? ~last_gnt : (req[1] ? M1 : M0);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer for two masters in front of a single-port data memory.
// Handshake: req is a level held with we/addr/wdata stable until a one-cycle ack
// (err valid with it); the master drops req the cycle after ack.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int WORD_AW = DEF_WORD_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [DATA_W-1:0]  m0_wdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [DATA_W-1:0]  m1_wdata,
  output logic               m0_ack,
  output logic               m0_err,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic               m1_ack,
  output logic               m1_err,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [1:0]         o_dbg_state
);

  logic [1:0]         r_state;
  logic               r_last_gnt;
  logic               r_gnt_id;
  logic               r_we;
  logic               r_bad;
  logic [WORD_AW-1:0] r_maddr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_ack0, r_ack1, r_err0, r_err1;
  logic [DATA_W-1:0]  r_rdata0, r_rdata1;

  logic               w_gnt_valid;
  logic               w_gnt_id;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_bad;
  logic               w_serve;

  rr_arb2 u_arb (
    .req       ({m1_req, m0_req}),
    .last_gnt  (r_last_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_sel_we    = w_gnt_id ? m1_we    : m0_we;
  assign w_sel_addr  = w_gnt_id ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt_id ? m1_wdata : m0_wdata;
  // Word-aligned and inside the 2^WORD_AW-word memory, else rejected.
  assign w_sel_bad   = (w_sel_addr[1:0] != 2'b00) ||
                       (w_sel_addr[ADDR_W-1:WORD_AW+2] != '0);

  // Enables decode straight from state so an async reset kills them at once.
  assign w_serve   = (r_state == SERVE) && !r_bad;
  assign mem_read  = w_serve && !r_we;
  assign mem_write = w_serve && r_we;
  assign mem_addr  = r_maddr;
  assign mem_wdata = r_wdata;

  assign m0_ack      = r_ack0;
  assign m0_err      = r_err0;
  assign m0_rdata    = r_rdata0;
  assign m1_ack      = r_ack1;
  assign m1_err      = r_err1;
  assign m1_rdata    = r_rdata1;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= M1;
      r_gnt_id   <= M0;
      r_we       <= 1'b0;
      r_bad      <= 1'b0;
      r_maddr    <= '0;
      r_wdata    <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_id <= w_gnt_id;
            r_we     <= w_sel_we;
            r_bad    <= w_sel_bad;
            r_maddr  <= w_sel_addr[WORD_AW+1:2];
            r_wdata  <= w_sel_wdata;
            r_state  <= SERVE;
          end
        end
        SERVE: begin
          if (!r_we && !r_bad) begin
            if (r_gnt_id == M0) r_rdata0 <= mem_rdata;
            else                r_rdata1 <= mem_rdata;
          end
          if (r_gnt_id == M0) begin
            r_ack0 <= 1'b1;
            r_err0 <= r_bad;
          end else begin
            r_ack1 <= 1'b1;
            r_err1 <= r_bad;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_last_gnt <= r_gnt_id;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 16K-word memory behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:16383];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m0_rdata   (m0_rdata),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .m1_rdata   (m1_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // Garbage when not reading, so a capture in the wrong cycle shows up.
  assign mem_rdata = mem_read ? mem[mem_addr] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_state"},  32'(dbg_state), 32'd0);
    chk({pfx, "_m0_ack"}, 32'(m0_ack),    32'd0);
    chk({pfx, "_m1_ack"}, 32'(m1_ack),    32'd0);
    chk({pfx, "_m0_err"}, 32'(m0_err),    32'd0);
    chk({pfx, "_m1_err"}, 32'(m1_err),    32'd0);
    chk({pfx, "_rd_en"},  32'(mem_read),  32'd0);
    chk({pfx, "_wr_en"},  32'(mem_write), 32'd0);
    chk({pfx, "_maddr"},  32'(mem_addr),  32'd0);
    chk({pfx, "_mwdata"}, mem_wdata,      32'd0);
    chk({pfx, "_m0_rd"},  m0_rdata,       32'd0);
    chk({pfx, "_m1_rd"},  m1_rdata,       32'd0);
  endtask

  task automatic drive(input logic m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 1'b0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // One isolated request from IDLE: check SERVE, DONE and the return to IDLE.
  task automatic single(input string tag, input logic m, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [13:0] exp_maddr,
                        input logic [31:0] exp_rd);
    @(negedge clk);
    drive(m, 1'b1, we, addr, wdata);
    @(negedge clk);
    chk({tag, "_serve_state"}, 32'(dbg_state), 32'd1);
    chk({tag, "_serve_rd_en"}, 32'(mem_read),  32'(!we && !exp_err));
    chk({tag, "_serve_wr_en"}, 32'(mem_write), 32'(we && !exp_err));
    if (!exp_err) chk({tag, "_maddr"}, 32'(mem_addr), 32'(exp_maddr));
    if (!exp_err && we) chk({tag, "_mwdata"}, mem_wdata, wdata);
    @(negedge clk);
    chk({tag, "_ack"},       32'(m ? m1_ack : m0_ack), 32'd1);
    chk({tag, "_other_ack"}, 32'(m ? m0_ack : m1_ack), 32'd0);
    chk({tag, "_err"},       32'(m ? m1_err : m0_err), 32'(exp_err));
    chk({tag, "_rdata"},     m ? m1_rdata : m0_rdata,  exp_rd);
    chk({tag, "_done_en"},   32'(mem_read | mem_write), 32'd0);
    drive(m, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk({tag, "_ack_clear"}, 32'(m0_ack | m1_ack), 32'd0);
    chk({tag, "_idle"},      32'(dbg_state), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    mem[4] = 32'hDEAD_BEEF;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    single("ld_m0_10",  1'b0, 1'b0, 32'h0000_0010, 32'd0,          1'b0, 14'd4, 32'hDEAD_BEEF);
    single("st_m1_20",  1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678,  1'b0, 14'd8, 32'd0);
    chk("st_m1_20_mem", mem[8], 32'h1234_5678);
    single("ld_m0_20",  1'b0, 1'b0, 32'h0000_0020, 32'd0,          1'b0, 14'd8, 32'h1234_5678);
    single("mis_m0_06", 1'b0, 1'b0, 32'h0000_0006, 32'd0,          1'b1, 14'd0, 32'h1234_5678);
    single("oor_m1",    1'b1, 1'b0, 32'h0001_0000, 32'd0,          1'b1, 14'd0, 32'd0);
    single("oor_st_m0", 1'b0, 1'b1, 32'h0001_0020, 32'hFFFF_FFFF,  1'b1, 14'd0, 32'h1234_5678);
    chk("oor_st_mem8", mem[8], 32'h1234_5678);
    single("ld_m1_10",  1'b1, 1'b0, 32'h0000_0010, 32'd0,          1'b0, 14'd4, 32'hDEAD_BEEF);

    // Both masters hold req from reset: m0 first, then strict alternation.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("cont_m0_ack_%0d", k), 32'(m0_ack),   32'(k % 6 == 2));
      chk($sformatf("cont_m1_ack_%0d", k), 32'(m1_ack),   32'(k % 6 == 5));
      chk($sformatf("cont_rd_%0d", k),     32'(mem_read), 32'(k % 3 == 1));
      chk($sformatf("cont_ovl_%0d", k),    32'(mem_read & mem_write), 32'd0);
      if (k % 6 == 2) chk($sformatf("cont_m0_rd_%0d", k), m0_rdata, 32'hDEAD_BEEF);
      if (k % 6 == 5) chk($sformatf("cont_m1_rd_%0d", k), m1_rdata, 32'h1234_5678);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // A req held through its ack is served again three cycles later.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("hold_m1_ack_%0d", k), 32'(m1_ack),   32'(k % 3 == 2));
      chk($sformatf("hold_rd_%0d", k),     32'(mem_read), 32'(k % 3 == 1));
      if (k % 3 == 1) chk($sformatf("hold_maddr_%0d", k), 32'(mem_addr), 32'd4);
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Reset lands mid-SERVE of a store: the write must vanish before the edge.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D);
    @(negedge clk);
    chk("rs_wr_before", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rs_wr_drop", 32'(mem_write), 32'd0);
    chk("rs_state_drop", 32'(dbg_state), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rs_mem12", mem[12], 32'd0);
    chk("rs_no_ack", 32'(m0_ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_rs");
    repeat (3) @(negedge clk);
    chk("rs_still_no_ack", 32'(m0_ack | m1_ack), 32'd0);
    chk("rs_mem12_final", mem[12], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
